// File: rtl/uart_rom_loader_if.sv
// ============================================================================
// Module   : uart_rom_loader_if
// Brief    : Byte-stream input and ROM-write/status outputs of uart_rom_loader.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface uart_rom_loader_if #(
    parameter int ADDR_W = 18
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              busy;
    logic              done;
    logic              error;
    logic [1:0]        err_code;
    logic [23:0]       loaded_len;

    modport slave (
        input  rx_valid, rx_data,
        output mem_we, mem_addr, mem_wdata, busy, done, error, err_code, loaded_len
    );

    modport master (
        output rx_valid, rx_data,
        input  mem_we, mem_addr, mem_wdata, busy, done, error, err_code, loaded_len
    );
endinterface

`default_nettype wire

// File: rtl/uart_rom_loader.sv
// ============================================================================
// Module   : uart_rom_loader
// Brief    : Parses framed UART image packets and writes the payload into the
//            cartridge ROM buffer. Define UART_ROM_LOADER_CHECKSUM_EN to require
//            a trailing mod-256 checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rom_loader #(
    parameter int DEPTH          = 143360,
    parameter int ADDR_W         = 18,
    parameter int TIMEOUT_CYCLES = 1_250_000
) (
    input  logic                clk,
    input  logic                rst,
    uart_rom_loader_if.slave    bus
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_SYNC = 3'd1;
    localparam logic [2:0] c_LEN0 = 3'd2;
    localparam logic [2:0] c_LEN1 = 3'd3;
    localparam logic [2:0] c_LEN2 = 3'd4;
    localparam logic [2:0] c_DATA = 3'd5;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
    localparam logic [2:0] c_CSUM = 3'd6;
`endif

    localparam int                 c_CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [23:0]        c_DEPTH   = 24'(DEPTH);

    logic [2:0]         r_state;
    logic [23:0]        r_len;
    logic [ADDR_W-1:0]  r_idx;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [7:0]         r_mem_wdata;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic [1:0]         r_err_code;
    logic [23:0]        r_loaded_len;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
    logic [7:0]         r_csum;
`endif

    logic [23:0] w_len_full;
    logic        w_last;

    assign w_len_full = {bus.rx_data, r_len[15:0]};
    assign w_last     = (24'(r_idx) == (r_len - 24'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_len        <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_err_code   <= 2'b00;
            r_loaded_len <= '0;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            r_mem_we <= 1'b0;

            // An arriving byte always beats an expiring timeout.
            if (r_state == c_IDLE || bus.rx_valid) begin
                r_cnt <= '0;
            end else if (r_cnt == c_TO_LAST) begin
                r_cnt      <= '0;
                r_busy     <= 1'b0;
                r_error    <= 1'b1;
                r_err_code <= 2'b11;
                r_state    <= c_IDLE;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            if (bus.rx_valid) begin
                case (r_state)
                    c_IDLE: begin
                        if (bus.rx_data == 8'h55) begin
                            r_done     <= 1'b0;
                            r_error    <= 1'b0;
                            r_err_code <= 2'b00;
                            r_busy     <= 1'b1;
                            r_state    <= c_SYNC;
                        end
                    end
                    c_SYNC: begin
                        if (bus.rx_data == 8'hAA) begin
                            r_state <= c_LEN0;
                        end else if (bus.rx_data != 8'h55) begin
                            r_busy  <= 1'b0;
                            r_state <= c_IDLE;
                        end
                    end
                    c_LEN0: begin
                        r_len[7:0] <= bus.rx_data;
                        r_state    <= c_LEN1;
                    end
                    c_LEN1: begin
                        r_len[15:8] <= bus.rx_data;
                        r_state     <= c_LEN2;
                    end
                    c_LEN2: begin
                        r_len <= w_len_full;
                        if (w_len_full == 24'd0 || w_len_full > c_DEPTH) begin
                            r_busy     <= 1'b0;
                            r_error    <= 1'b1;
                            r_err_code <= 2'b01;
                            r_state    <= c_IDLE;
                        end else begin
                            r_idx   <= '0;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
                            r_csum  <= '0;
`endif
                            r_state <= c_DATA;
                        end
                    end
                    c_DATA: begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_idx;
                        r_mem_wdata <= bus.rx_data;
                        r_idx       <= r_idx + ADDR_W'(1);
`ifdef UART_ROM_LOADER_CHECKSUM_EN
                        r_csum      <= r_csum + bus.rx_data;
                        if (w_last) begin
                            r_state <= c_CSUM;
                        end
`else
                        if (w_last) begin
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                            r_loaded_len <= r_len;
                            r_state      <= c_IDLE;
                        end
`endif
                    end
`ifdef UART_ROM_LOADER_CHECKSUM_EN
                    c_CSUM: begin
                        r_busy <= 1'b0;
                        if (bus.rx_data == r_csum) begin
                            r_done       <= 1'b1;
                            r_loaded_len <= r_len;
                        end else begin
                            r_error    <= 1'b1;
                            r_err_code <= 2'b10;
                        end
                        r_state <= c_IDLE;
                    end
`endif
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.error      = r_error;
    assign bus.err_code   = r_err_code;
    assign bus.loaded_len = r_loaded_len;

endmodule

`default_nettype wire

// File: tb/tb_uart_rom_loader.sv
// ============================================================================
// Module   : tb_uart_rom_loader
// Brief    : Directed self-checking bench for uart_rom_loader (both checksum
//            builds, selected by UART_ROM_LOADER_CHECKSUM_EN).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rom_loader;

    localparam int ADDR_W = 18;
    localparam int TO     = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rom_loader_if #(.ADDR_W(ADDR_W)) bus();

    uart_rom_loader #(
        .DEPTH          (143360),
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    int                wr_cnt = 0;
    logic [ADDR_W-1:0] wr_addr [256];
    logic [7:0]        wr_data [256];

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_addr[wr_cnt % 256] <= bus.mem_addr;
            wr_data[wr_cnt % 256] <= bus.mem_wdata;
            wr_cnt                <= wr_cnt + 1;
        end
    end

    logic [7:0] pkt[$];

    task automatic send_pkt();
        foreach (pkt[i]) begin
            @(negedge clk);
            bus.rx_valid = 1'b1;
            bus.rx_data  = pkt[i];
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin
            fails++; $display("FAIL reset_mem: got we=%0b addr=%0h data=%0h, want 0", bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        tests++;
        if ({bus.busy, bus.done, bus.error, bus.err_code} !== 5'b0) begin
            fails++; $display("FAIL reset_status: got busy=%0b done=%0b err=%0b code=%0b, want 0", bus.busy, bus.done, bus.error, bus.err_code);
        end
        tests++;
        if (bus.loaded_len !== 24'd0) begin
            fails++; $display("FAIL reset_len: got %0h want 0", bus.loaded_len);
        end
        rst = 1'b0;
    endtask

    task automatic test_good_packet();
        int base;
        logic [7:0] exp_d [4];
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        base = wr_cnt;
        pkt = '{8'h55, 8'hAA, 8'h04, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef UART_ROM_LOADER_CHECKSUM_EN
        pkt.push_back(8'hAA);
`endif
        send_pkt();
`ifndef UART_ROM_LOADER_CHECKSUM_EN
        tests++;
        if (bus.mem_we !== 1'b1) begin
            fails++; $display("FAIL good_last_we_with_done: got %0b want 1", bus.mem_we);
        end
`endif
        tests++;
        if (wr_cnt - base !== 4) begin
            fails++; $display("FAIL good_wr_count: got %0d want 4", wr_cnt - base);
        end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (wr_addr[(base + k) % 256] !== ADDR_W'(k) || wr_data[(base + k) % 256] !== exp_d[k]) begin
                fails++; $display("FAIL good_write%0d: got addr=%0h data=%0h want addr=%0h data=%0h",
                                  k, wr_addr[(base + k) % 256], wr_data[(base + k) % 256], k, exp_d[k]);
            end
        end
        tests++;
        if ({bus.done, bus.error, bus.busy, bus.err_code} !== 5'b10000) begin
            fails++; $display("FAIL good_status: got done=%0b err=%0b busy=%0b code=%0b want 1/0/0/00", bus.done, bus.error, bus.busy, bus.err_code);
        end
        tests++;
        if (bus.loaded_len !== 24'd4) begin
            fails++; $display("FAIL good_len: got %0d want 4", bus.loaded_len);
        end
    endtask

`ifdef UART_ROM_LOADER_CHECKSUM_EN
    task automatic test_bad_csum();
        int base;
        base = wr_cnt;
        pkt = '{8'h55, 8'hAA, 8'h04, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        send_pkt();
        tests++;
        if (wr_cnt - base !== 4) begin
            fails++; $display("FAIL csum_wr_count: got %0d want 4", wr_cnt - base);
        end
        tests++;
        if ({bus.done, bus.error, bus.busy, bus.err_code} !== 5'b01010) begin
            fails++; $display("FAIL csum_status: got done=%0b err=%0b busy=%0b code=%0b want 0/1/0/10", bus.done, bus.error, bus.busy, bus.err_code);
        end
    endtask
`endif

    task automatic test_bad_length();
        int base;
        base = wr_cnt;
        pkt = '{8'h55, 8'hAA, 8'h00, 8'h00, 8'h00};
        send_pkt();
        tests++;
        if ({bus.done, bus.error, bus.busy, bus.err_code} !== 5'b01001) begin
            fails++; $display("FAIL len0_status: got done=%0b err=%0b busy=%0b code=%0b want 0/1/0/01", bus.done, bus.error, bus.busy, bus.err_code);
        end
        pkt = '{8'h55, 8'hAA, 8'h01, 8'h30, 8'h02};
        send_pkt();
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if ({bus.done, bus.error, bus.busy, bus.err_code} !== 5'b01001) begin
            fails++; $display("FAIL lenmax_status: got done=%0b err=%0b busy=%0b code=%0b want 0/1/0/01", bus.done, bus.error, bus.busy, bus.err_code);
        end
        tests++;
        if (wr_cnt - base !== 0) begin
            fails++; $display("FAIL badlen_writes: got %0d want 0", wr_cnt - base);
        end
    endtask

    task automatic test_timeout();
        int base;
        int n;
        base = wr_cnt;
        pkt = '{8'h55, 8'hAA, 8'h02, 8'h00, 8'h00, 8'h11};
        send_pkt();
        n = 0;
        while (bus.error !== 1'b1 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        tests++;
        if (n !== TO) begin
            fails++; $display("FAIL timeout_latency: got %0d cycles want %0d", n + 1, TO + 1);
        end
        tests++;
        if ({bus.done, bus.error, bus.busy, bus.err_code} !== 5'b01011) begin
            fails++; $display("FAIL timeout_status: got done=%0b err=%0b busy=%0b code=%0b want 0/1/0/11", bus.done, bus.error, bus.busy, bus.err_code);
        end
        tests++;
        if (wr_cnt - base !== 1) begin
            fails++; $display("FAIL timeout_writes: got %0d want 1", wr_cnt - base);
        end

        pkt = '{8'h55, 8'hAA, 8'h01, 8'h00, 8'h00, 8'h5A};
`ifdef UART_ROM_LOADER_CHECKSUM_EN
        pkt.push_back(8'h5A);
`endif
        send_pkt();
        tests++;
        if ({bus.done, bus.error, bus.err_code} !== 4'b1000) begin
            fails++; $display("FAIL recover_status: got done=%0b err=%0b code=%0b want 1/0/00", bus.done, bus.error, bus.err_code);
        end

        // Byte lands in exactly the cycle the timeout would expire.
        base = wr_cnt;
        pkt = '{8'h55, 8'hAA, 8'h01, 8'h00, 8'h00};
        send_pkt();
        repeat (TO - 1) @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h3C;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        #1;
        tests++;
        if (bus.error !== 1'b0) begin
            fails++; $display("FAIL edge_no_timeout: got error=%0b code=%0b want 0", bus.error, bus.err_code);
        end
`ifdef UART_ROM_LOADER_CHECKSUM_EN
        pkt = '{8'h3C};
        send_pkt();
`endif
        tests++;
        if (bus.done !== 1'b1 || bus.loaded_len !== 24'd1) begin
            fails++; $display("FAIL edge_done: got done=%0b len=%0d want 1/1", bus.done, bus.loaded_len);
        end
        tests++;
        if (wr_cnt - base !== 1 || wr_data[base % 256] !== 8'h3C) begin
            fails++; $display("FAIL edge_write: got count=%0d data=%0h want 1/3c", wr_cnt - base, wr_data[base % 256]);
        end
    endtask

    task automatic test_noise();
        int base;
        base = wr_cnt;
        pkt = '{8'h00, 8'h55, 8'h55, 8'hAA, 8'h01, 8'h00, 8'h00, 8'h7E};
`ifdef UART_ROM_LOADER_CHECKSUM_EN
        pkt.push_back(8'h7E);
`endif
        send_pkt();
        tests++;
        if (wr_cnt - base !== 1 || wr_addr[base % 256] !== '0 || wr_data[base % 256] !== 8'h7E) begin
            fails++; $display("FAIL noise_write: got count=%0d addr=%0h data=%0h want 1/0/7e", wr_cnt - base, wr_addr[base % 256], wr_data[base % 256]);
        end
        tests++;
        if (bus.done !== 1'b1 || bus.loaded_len !== 24'd1) begin
            fails++; $display("FAIL noise_done: got done=%0b len=%0d want 1/1", bus.done, bus.loaded_len);
        end
        pkt = '{8'h55};
        send_pkt();
        tests++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            fails++; $display("FAIL noise_sync: got busy=%0b done=%0b want 1/0", bus.busy, bus.done);
        end
        pkt = '{8'h13};
        send_pkt();
        tests++;
        if ({bus.busy, bus.error, bus.err_code} !== 4'b0000) begin
            fails++; $display("FAIL noise_abort: got busy=%0b err=%0b code=%0b want 0/0/00", bus.busy, bus.error, bus.err_code);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        pkt = '{8'h55, 8'hAA, 8'h08, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03};
        send_pkt();
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if ({bus.mem_we, bus.busy, bus.mem_addr, bus.mem_wdata} !== '0) begin
            fails++; $display("FAIL rstmid_async: got we=%0b busy=%0b addr=%0h data=%0h want 0", bus.mem_we, bus.busy, bus.mem_addr, bus.mem_wdata);
        end
        base = wr_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        pkt = '{8'h04, 8'h05, 8'h06};
        send_pkt();
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (wr_cnt - base !== 0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL rstmid_quiet: got writes=%0d busy=%0b want 0/0", wr_cnt - base, bus.busy);
        end
        base = wr_cnt;
        pkt = '{8'h55, 8'hAA, 8'h02, 8'h00, 8'h00, 8'hA1, 8'hB2};
`ifdef UART_ROM_LOADER_CHECKSUM_EN
        pkt.push_back(8'h53);
`endif
        send_pkt();
        tests++;
        if (wr_cnt - base !== 2 || wr_data[(base + 1) % 256] !== 8'hB2 || wr_addr[(base + 1) % 256] !== ADDR_W'(1)) begin
            fails++; $display("FAIL rstmid_reload_writes: got count=%0d addr1=%0h data1=%0h want 2/1/b2",
                              wr_cnt - base, wr_addr[(base + 1) % 256], wr_data[(base + 1) % 256]);
        end
        tests++;
        if (bus.done !== 1'b1 || bus.error !== 1'b0 || bus.loaded_len !== 24'd2) begin
            fails++; $display("FAIL rstmid_reload_status: got done=%0b err=%0b len=%0d want 1/0/2", bus.done, bus.error, bus.loaded_len);
        end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        test_reset();
        test_good_packet();
`ifdef UART_ROM_LOADER_CHECKSUM_EN
        test_bad_csum();
`endif
        test_bad_length();
        test_timeout();
        test_noise();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rom_loader.md
# uart_rom_loader

Packet parser that sits directly downstream of the UART receiver in the 8Bit_InfinityCartridge design. It consumes received bytes as one-cycle `rx_valid` strobes, finds a framed image packet (sync, 24-bit length, payload, optional checksum), and writes each payload byte to the cartridge ROM buffer at consecutive addresses from 0. It reports completion, length and error status to the cartridge control logic.

## Interface
- `DEPTH`, 143360: ROM buffer size in bytes (140 KB); maximum accepted payload length.
- `ADDR_W`, 18: width of `mem_addr`.
- `TIMEOUT_CYCLES`, 1_250_000: inter-byte timeout, 10 ms at 125 MHz.
- `clk` in 1: system clock, 125 MHz.
- `rst` in 1: reset, asynchronous, active-high.
- `rx_valid` in 1: one-cycle strobe, `rx_data` holds a received byte.
- `rx_data` in 8: received byte.
- `mem_we` out 1: one-cycle ROM write strobe.
- `mem_addr` out ADDR_W: write address.
- `mem_wdata` out 8: write data.
- `busy` out 1: packet in progress.
- `done` out 1: sticky, last packet loaded successfully.
- `error` out 1: sticky, last packet failed.
- `err_code` out 2: 01 bad length, 10 checksum mismatch, 11 timeout; 00 when `error`=0.
- `loaded_len` out 24: length of the last successful packet.

## Operation
- Packet format: 0x55, 0xAA, LEN[7:0], LEN[15:8], LEN[23:16], LEN payload bytes, then one checksum byte when checksum support is built in (see Configuration).
- States: IDLE, SYNC, LEN0, LEN1, LEN2, DATA, CSUM.
- IDLE: 0x55 moves to SYNC, clears `done`, `error` and `err_code`, and sets `busy`. Any other byte is ignored.
- SYNC: 0xAA moves to LEN0. 0x55 stays in SYNC. Any other byte returns to IDLE and clears `busy`; no error is flagged.
- LEN0..LEN2: assemble the little-endian 24-bit length. After LEN2, if LEN==0 or LEN>DEPTH: set `error`, `err_code`=01, go to IDLE. Otherwise clear the index and the checksum accumulator and go to DATA.
- DATA, per byte: write to `mem_addr`=index, increment index, and add the byte to the 8-bit accumulator (sum mod 256). After the LEN-th byte, go to CSUM, or finish directly when checksum support is compiled out.
- CSUM: if the byte equals the accumulator, set `done` and set `loaded_len`=LEN. Otherwise set `error` with `err_code`=10. Go to IDLE in both cases. Payload bytes already written are not rolled back.
- Timeout: a counter clears on every `rx_valid` and counts in every state except IDLE. When it reaches TIMEOUT_CYCLES, set `error`, `err_code`=11, go to IDLE.
- Terminal condition, any kind: `busy` drops in the same cycle that `done` or `error` rises.
- `done` and `error` are mutually exclusive. Both hold until the next accepted 0x55 or reset.

## Timing
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `error`=0, `err_code`=00, `loaded_len`=0. State returns to IDLE.
- Reset mid-packet aborts immediately; `mem_we` is forced low asynchronously.
- Payload byte with `rx_valid` at cycle N: `mem_we`, `mem_addr` and `mem_wdata` are registered and valid at N+1 for exactly one cycle.
- Final byte at cycle M (checksum byte, or last payload byte without checksum): `done` or `error` is set at M+1. Without checksum, the final `mem_we` pulse coincides with `done`.
- Timeout: with the last byte at cycle T, `error` rises at T+TIMEOUT_CYCLES+1.
- `rx_valid` in the same cycle the timeout would fire: the byte wins, the counter clears, and no error is raised.
- The block accepts back-to-back `rx_valid`, one byte per cycle.
- `mem_addr` never exceeds LEN-1, which is at most DEPTH-1; there is no wrap-around.

## Configuration
- `UART_ROM_LOADER_CHECKSUM_EN` defined: the CSUM state and the accumulator are present, the trailing checksum byte is required, and error code 10 is possible.
- Not defined: no checksum byte is expected. `done` is set at M+1 after the LEN-th payload byte. Error code 10 never occurs.

## Test plan
- Checksum enabled; send 55 AA 04 00 00 11 22 33 44 AA -> four `mem_we` pulses at addresses 0..3 with data 11/22/33/44; `done`=1, `loaded_len`=4, `error`=0.
- Same packet with checksum byte 00 -> four writes occur; `error`=1, `err_code`=10, `done`=0.
- Send 55 AA 00 00 00 -> `error`=1, `err_code`=01, no `mem_we`. Repeat with LEN=0x023001 (143361) -> `err_code`=01.
- TIMEOUT_CYCLES=100; send 55 AA 02 00 00 11, then idle -> exactly one write; `error`=1, `err_code`=11 exactly 101 cycles after the last strobe. A fresh valid packet afterwards clears `error` and sets `done`.
- Noise then packet: 00 55 55 AA 01 00 00 7E 7E -> single write of 7E to address 0, `done`=1. Noise 55 13 -> returns to IDLE with `busy`=0, no error.
- Assert `rst` for 3 cycles mid-payload -> all outputs at reset values at once, and no `mem_we` afterwards. The next valid packet loads normally.
